// File: rtl/dram_fifo64x7.sv
// 64-entry, 7-bit FIFO that keeps its storage in an external RAM64M8 and holds one entry in an
// output register. Define DRAMFIFO_LEVEL_EN to build the LEVEL/AFULL/AEMPTY logic.
module dram_fifo64x7 #(
  parameter logic [6:0] AFULL_THR        = 7'd48,
  parameter logic [6:0] AEMPTY_THR       = 7'd16,
  parameter bit         IS_WCLK_INVERTED = 1'b0
) (
  input  logic       WCLK,
  input  logic       RSTN,
  input  logic       S_VALID,
  output logic       S_READY,
  input  logic [6:0] S_DATA,
  output logic       M_VALID,
  input  logic       M_READY,
  output logic [6:0] M_DATA,
  output logic [6:0] LEVEL,
  output logic       AFULL,
  output logic       AEMPTY,
  output logic       RAM_WE,
  output logic [5:0] RAM_WADDR,
  output logic [6:0] RAM_DI,
  output logic [5:0] RAM_RADDR,
  input  logic [6:0] RAM_DO
);

  localparam logic [6:0] Capacity = 7'd64;

  logic       w_clk;
  logic       w_push;
  logic       w_pop;
  logic       w_load;
  logic [6:0] w_ram_cnt;
  logic [6:0] w_wptr_d;
  logic [6:0] w_rptr_d;
  logic       w_m_valid_d;
  logic [6:0] w_m_data_d;
  logic       w_s_ready_d;

  // Pointers carry an extra wrap bit so their difference gives the RAM occupancy 0..64.
  logic [6:0] r_wptr;
  logic [6:0] r_rptr;
  logic       r_s_ready;
  logic       r_m_valid;
  logic [6:0] r_m_data;

  assign w_clk = WCLK ^ IS_WCLK_INVERTED;

  assign w_push    = S_VALID & r_s_ready;
  assign w_pop     = r_m_valid & M_READY;
  assign w_ram_cnt = r_wptr - r_rptr;

  // Occupancy comes from registered pointers only, so an entry written at an edge is first
  // visible to the output register one edge later.
  assign w_load = (w_ram_cnt != 7'd0) & (~r_m_valid | w_pop);

  always_comb begin
    w_wptr_d    = r_wptr;
    w_rptr_d    = r_rptr;
    w_m_valid_d = r_m_valid;
    w_m_data_d  = r_m_data;
    if (w_push) begin
      w_wptr_d = r_wptr + 7'd1;
    end
    if (w_load) begin
      w_rptr_d    = r_rptr + 7'd1;
      w_m_valid_d = 1'b1;
      w_m_data_d  = RAM_DO;
    end else if (w_pop) begin
      w_m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge w_clk or negedge RSTN) begin
    if (!RSTN) begin
      r_wptr    <= 7'd0;
      r_rptr    <= 7'd0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= 7'h0;
    end else begin
      r_wptr    <= w_wptr_d;
      r_rptr    <= w_rptr_d;
      r_s_ready <= w_s_ready_d;
      r_m_valid <= w_m_valid_d;
      r_m_data  <= w_m_data_d;
    end
  end

`ifdef DRAMFIFO_LEVEL_EN
  logic [6:0] w_level_d;
  logic [6:0] r_level;
  logic       r_afull;
  logic       r_aempty;

  always_comb begin
    w_level_d = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_d = r_level + 7'd1;
      2'b01:   w_level_d = r_level - 7'd1;
      default: w_level_d = r_level;
    endcase
  end

  assign w_s_ready_d = (w_level_d < Capacity);

  // Flags are computed from next-state level so they line up with LEVEL every cycle.
  always_ff @(posedge w_clk or negedge RSTN) begin
    if (!RSTN) begin
      r_level  <= 7'd0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_level  <= w_level_d;
      r_afull  <= (w_level_d >= AFULL_THR);
      r_aempty <= (w_level_d <= AEMPTY_THR);
    end
  end

  assign LEVEL  = r_level;
  assign AFULL  = r_afull;
  assign AEMPTY = r_aempty;
`else
  logic [6:0] w_occ_d;

  // Total occupancy = RAM entries (pointer difference) plus the output register.
  assign w_occ_d     = (w_wptr_d - w_rptr_d) + {6'd0, w_m_valid_d};
  assign w_s_ready_d = (w_occ_d < Capacity);

  assign LEVEL  = 7'd0;
  assign AFULL  = 1'b0;
  assign AEMPTY = 1'b0;
`endif

  assign S_READY   = r_s_ready;
  assign M_VALID   = r_m_valid;
  assign M_DATA    = r_m_data;
  assign RAM_WE    = w_push;
  assign RAM_WADDR = r_wptr[5:0];
  assign RAM_DI    = S_DATA;
  assign RAM_RADDR = r_rptr[5:0];

endmodule

// File: tb/tb_dram_fifo64x7.sv
// Directed bench for dram_fifo64x7 with behavioural RAM64M8 models; one rising-edge instance
// and one IS_WCLK_INVERTED=1 instance.
module tb_dram_fifo64x7;

`ifdef DRAMFIFO_LEVEL_EN
  localparam bit LvlEn = 1'b1;
`else
  localparam bit LvlEn = 1'b0;
`endif

  logic       clk;
  logic       rstn;
  logic       s_valid, m_ready;
  logic [6:0] s_data;
  logic       s_ready, m_valid, afull, aempty, ram_we;
  logic [6:0] m_data, level, ram_di, ram_do;
  logic [5:0] ram_waddr, ram_raddr;
  logic [6:0] mem [64];

  logic       i_s_valid, i_m_ready;
  logic [6:0] i_s_data;
  logic       i_s_ready, i_m_valid, i_afull, i_aempty, i_ram_we;
  logic [6:0] i_m_data, i_level, i_ram_di, i_ram_do;
  logic [5:0] i_ram_waddr, i_ram_raddr;
  logic [6:0] i_mem [64];

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_di;
  assign ram_do = mem[ram_raddr];
  always @(negedge clk) if (i_ram_we) i_mem[i_ram_waddr] <= i_ram_di;
  assign i_ram_do = i_mem[i_ram_raddr];

  dram_fifo64x7 u_dut (
    .WCLK(clk), .RSTN(rstn), .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
    .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data), .LEVEL(level), .AFULL(afull),
    .AEMPTY(aempty), .RAM_WE(ram_we), .RAM_WADDR(ram_waddr), .RAM_DI(ram_di),
    .RAM_RADDR(ram_raddr), .RAM_DO(ram_do)
  );

  dram_fifo64x7 #(.IS_WCLK_INVERTED(1'b1)) u_dut_inv (
    .WCLK(clk), .RSTN(rstn), .S_VALID(i_s_valid), .S_READY(i_s_ready), .S_DATA(i_s_data),
    .M_VALID(i_m_valid), .M_READY(i_m_ready), .M_DATA(i_m_data), .LEVEL(i_level),
    .AFULL(i_afull), .AEMPTY(i_aempty), .RAM_WE(i_ram_we), .RAM_WADDR(i_ram_waddr),
    .RAM_DI(i_ram_di), .RAM_RADDR(i_ram_raddr), .RAM_DO(i_ram_do)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         sent, recv, lvl;
    logic [5:0] mw;

    rstn = 1'b0; s_valid = 1'b1; s_data = 7'h33; m_ready = 1'b0;
    i_s_valid = 1'b0; i_s_data = 7'h0; i_m_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_level", level, 0);
    chk("rst_afull", afull, 0);
    chk("rst_aempty", aempty, LvlEn ? 8'd1 : 8'd0);
    chk("rst_ram_we", ram_we, 0);
    s_valid = 1'b0;
    tick();
    chk("rst_held_ready", s_ready, 0);
    #1 rstn = 1'b1;
    #1 chk("rel_no_edge_ready", s_ready, 0);
    tick();
    chk("rel_first_edge_ready", s_ready, 1);

    // Single beat
    s_valid = 1'b1; s_data = 7'h5A;
    #1;
    chk("sb_we", ram_we, 1);
    chk("sb_waddr", ram_waddr, 0);
    chk("sb_di", ram_di, 8'h5A);
    tick();
    s_valid = 1'b0;
    #1;
    chk("sb_e0_valid", m_valid, 0);
    chk("sb_e0_level", level, LvlEn ? 8'd1 : 8'd0);
    chk("sb_e0_we", ram_we, 0);
    tick();
    chk("sb_e1_valid", m_valid, 1);
    chk("sb_e1_data", m_data, 8'h5A);
    chk("sb_e1_level", level, LvlEn ? 8'd1 : 8'd0);
    chk("sb_e1_raddr", ram_raddr, 1);
    chk("sb_e1_aempty", aempty, LvlEn ? 8'd1 : 8'd0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("sb_pop_valid", m_valid, 0);
    chk("sb_pop_hold", m_data, 8'h5A);
    chk("sb_pop_level", level, 0);

    // Fill with 64 beats, data i+3, starting at address 1
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1; s_data = 7'(i + 3);
      #1;
      chk("fill_ready", s_ready, 1);
      chk("fill_waddr", ram_waddr, 8'((i + 1) % 64));
      tick();
      chk("fill_level", level, LvlEn ? 8'(i + 1) : 8'd0);
      chk("fill_afull", afull, (LvlEn && (i + 1) >= 48) ? 8'd1 : 8'd0);
      chk("fill_aempty", aempty, (LvlEn && (i + 1) <= 16) ? 8'd1 : 8'd0);
    end
    s_data = 7'h7F;
    chk("full_ready", s_ready, 0);
    chk("full_65th_we", ram_we, 0);
    chk("full_m_data", m_data, 3);
    tick();
    chk("full_hold_level", level, LvlEn ? 8'd64 : 8'd0);
    chk("full_hold_ready", s_ready, 0);

    // Full with simultaneous pop: push refused, ready next cycle
    m_ready = 1'b1;
    #1 chk("fp_we", ram_we, 0);
    tick();
    chk("fp_level", level, LvlEn ? 8'd63 : 8'd0);
    chk("fp_ready", s_ready, 1);
    chk("fp_data", m_data, 4);
    chk("fp_we_now", ram_we, 1);
    tick();
    s_valid = 1'b0;
    chk("pp_level", level, LvlEn ? 8'd63 : 8'd0);
    chk("pp_data", m_data, 5);
    for (int k = 0; k < 63; k++) begin
      chk("drain_valid", m_valid, 1);
      chk("drain_data", m_data, (k < 62) ? 8'(5 + k) : 8'h7F);
      tick();
    end
    m_ready = 1'b0;
    chk("drain_end_valid", m_valid, 0);
    chk("drain_end_level", level, 0);
    chk("drain_end_ready", s_ready, 1);

    // Random handshakes over 200 incrementing beats; pointers wrap past 63
    sent = 0; recv = 0; lvl = 0; mw = 6'd2;
    for (int cyc = 0; cyc < 4000 && recv < 200; cyc++) begin
      s_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
      s_data  = 7'(sent);
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (s_valid && s_ready) begin
        chk("wrap_waddr", ram_waddr, mw);
        mw++; sent++; lvl++;
      end
      if (m_valid && m_ready) begin
        chk("wrap_data", m_data, 8'(recv % 128));
        recv++; lvl--;
      end
      tick();
      chk("wrap_level", level, LvlEn ? 8'(lvl) : 8'd0);
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("wrap_count", 8'(recv), 8'd200);

    // Reset mid-stream at level 20
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 7'(i + 40);
      tick();
    end
    s_valid = 1'b0;
    chk("mid_level", level, LvlEn ? 8'd20 : 8'd0);
    chk("mid_valid", m_valid, 1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_aempty", aempty, LvlEn ? 8'd1 : 8'd0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_raddr", ram_raddr, 0);
    chk("mid_rst_waddr", ram_waddr, 0);
    #1 rstn = 1'b1;
    tick();
    chk("post_rst_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 7'h11;
    #1 chk("post_rst_waddr", ram_waddr, 0);
    tick();
    s_valid = 1'b0;
    tick();
    chk("post_rst_valid", m_valid, 1);
    chk("post_rst_data", m_data, 8'h11);
    chk("post_rst_raddr", ram_raddr, 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("post_rst_pop", m_valid, 0);

    // Inverted clock: single beat, all updates on falling edges
    @(negedge clk); #1;
    i_s_valid = 1'b1; i_s_data = 7'h5A;
    #1;
    chk("inv_we", i_ram_we, 1);
    chk("inv_waddr", i_ram_waddr, 0);
    chk("inv_ready", i_s_ready, 1);
    tick();
    chk("inv_rise_level", i_level, 0);
    chk("inv_rise_waddr", i_ram_waddr, 0);
    chk("inv_rise_valid", i_m_valid, 0);
    @(negedge clk); #1;
    i_s_valid = 1'b0;
    #1;
    chk("inv_e0_level", i_level, LvlEn ? 8'd1 : 8'd0);
    chk("inv_e0_waddr", i_ram_waddr, 1);
    chk("inv_e0_valid", i_m_valid, 0);
    tick();
    chk("inv_rise2_valid", i_m_valid, 0);
    @(negedge clk); #1;
    chk("inv_e1_valid", i_m_valid, 1);
    chk("inv_e1_data", i_m_data, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
